// File: rtl/hazard_sched_pkg.sv
// Shared types and helpers for the hazard scheduler.
//   reg_t / tim_t  : register index and stage-timing field widths
//   fwd_sel_e      : forwarding-mux select encoding (RF / M / W)
//   stage_t        : full E-stage tuple
//   res_t          : result-producing part of a tuple (M stage)
//   sat_dec        : saturating-at-zero decrement of a timing field
//   hazard_hit     : one source-vs-producer stall test
//   fwd_sel        : forward select for one operand register
package hazard_sched_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned T_W   = 2;

  typedef logic [REG_W-1:0] reg_t;
  typedef logic [T_W-1:0]   tim_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    reg_t r_new;
    tim_t t_new;
    reg_t r_use1;
    reg_t r_use2;
    logic md_start;
    logic md_div;
  } stage_t;

  typedef struct packed {
    reg_t r_new;
    tim_t t_new;
  } res_t;

  function automatic tim_t sat_dec(input tim_t t);
    return (t == '0) ? '0 : t - tim_t'(1);
  endfunction

  // $0 is never a real dependency, so an unused/zero source never hits.
  function automatic logic hazard_hit(input reg_t r_use, input tim_t t_use,
                                      input reg_t r_new, input tim_t t_new);
    return (r_use != '0) && (r_new == r_use) && (t_new > t_use);
  endfunction

  // M is younger than W, so it wins when both write the operand register.
  function automatic fwd_sel_e fwd_sel(input reg_t r, input res_t m,
                                       input reg_t w_r_new);
    if (r == '0)                          return FWD_RF;
    if ((m.r_new == r) && (m.t_new == '0)) return FWD_M;
    if (w_r_new == r)                     return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sched_md_busy_cnt.sv
// Busy-window counter for the multi-cycle mult/div unit.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : an md operation is in E at this edge
//   div_i         : qualifies start_i, 1 = divide
//   busy_o        : registered, high while the countdown is nonzero
module md_busy_cnt #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_sched.sv
// Stall / forwarding controller for the 5-stage MIPS pipeline.
// Shadows the D-stage timing tuple through E, M and W, ages the
// result timing, raises the D-stage stall and drives operand
// forwarding selects; sequences the mult/div busy window.
//   clk, rst_n            : clock, asynchronous active-low reset
//   d_r_use1/2, d_t_use1/2: D-stage sources and when they are needed
//   d_r_new, d_t_new      : D-stage destination and its result latency
//   d_md_start/div/use    : mult/div start, divide flag, hi/lo user
//   stall                 : freeze PC and F/D, bubble into E
//   fwd_d1/2, fwd_e1/2    : operand selects (0 RF, 1 M, 2 W)
//   md_busy               : mult/div unit computing
module hazard_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] d_r_use1,
  input  logic [4:0] d_r_use2,
  input  logic [1:0] d_t_use1,
  input  logic [1:0] d_t_use2,
  input  logic [4:0] d_r_new,
  input  logic [1:0] d_t_new,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_d1,
  output logic [1:0] fwd_d2,
  output logic [1:0] fwd_e1,
  output logic [1:0] fwd_e2,
  output logic       md_busy
);

  import hazard_sched_pkg::*;

  stage_t d_tup;
  stage_t e_q, e_d;
  res_t   m_q, m_d;
  // Only W's destination is ever consulted (it never stalls, and its
  // result is always ready), so its timing/source fields are not kept.
  reg_t   w_q, w_d;
  logic   hz_stall, md_stall;

  always_comb begin
    d_tup = '{r_new:    d_r_new,
              t_new:    d_t_new,
              r_use1:   d_r_use1,
              r_use2:   d_r_use2,
              md_start: d_md_start,
              md_div:   d_md_div};
    e_d       = stall ? '0 : d_tup;
    m_d.r_new = e_q.r_new;
    m_d.t_new = sat_dec(e_q.t_new);
    w_d       = m_q.r_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  always_comb begin
    hz_stall = hazard_hit(d_r_use1, d_t_use1, e_q.r_new, e_q.t_new) |
               hazard_hit(d_r_use1, d_t_use1, m_q.r_new, m_q.t_new) |
               hazard_hit(d_r_use2, d_t_use2, e_q.r_new, e_q.t_new) |
               hazard_hit(d_r_use2, d_t_use2, m_q.r_new, m_q.t_new);
    md_stall = d_md_use & (md_busy | e_q.md_start);
    stall    = hz_stall | md_stall;
  end

  always_comb begin
    fwd_d1 = fwd_sel(d_r_use1,   m_q, w_q);
    fwd_d2 = fwd_sel(d_r_use2,   m_q, w_q);
    fwd_e1 = fwd_sel(e_q.r_use1, m_q, w_q);
    fwd_e2 = fwd_sel(e_q.r_use2, m_q, w_q);
  end

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (e_q.md_start),
    .div_i   (e_q.md_div),
    .busy_o  (md_busy)
  );

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] d_r_use1, d_r_use2, d_r_new;
  logic [1:0] d_t_use1, d_t_use2, d_t_new;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2;

  always #5 clk = ~clk;

  hazard_sched #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_r_use1   (d_r_use1),
    .d_r_use2   (d_r_use2),
    .d_t_use1   (d_t_use1),
    .d_t_use2   (d_t_use2),
    .d_r_new    (d_r_new),
    .d_t_new    (d_t_new),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_d1     (fwd_d1),
    .fwd_d2     (fwd_d2),
    .fwd_e1     (fwd_e1),
    .fwd_e2     (fwd_e2),
    .md_busy    (md_busy)
  );

  typedef struct {
    logic [4:0] ru1;  logic [1:0] tu1;
    logic [4:0] ru2;  logic [1:0] tu2;
    logic [4:0] rn;   logic [1:0] tn;
    logic       mds, mdd, mdu;
    logic       st;
    logic [1:0] fd1, fd2, fe1, fe2;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_err     = 0;

  function automatic vec_t mk(
    input logic [4:0] ru1, input logic [1:0] tu1,
    input logic [4:0] ru2, input logic [1:0] tu2,
    input logic [4:0] rn,  input logic [1:0] tn,
    input logic mds, input logic mdd, input logic mdu,
    input logic st, input logic [1:0] fd1, input logic [1:0] fd2,
    input logic [1:0] fe1, input logic [1:0] fe2, input logic busy);
    vec_t v;
    v.ru1 = ru1; v.tu1 = tu1; v.ru2 = ru2; v.tu2 = tu2;
    v.rn = rn; v.tn = tn; v.mds = mds; v.mdd = mdd; v.mdu = mdu;
    v.st = st; v.fd1 = fd1; v.fd2 = fd2; v.fe1 = fe1; v.fe2 = fe2;
    v.busy = busy;
    return v;
  endfunction

  task automatic drive(input logic [4:0] ru1, input logic [1:0] tu1,
                       input logic [4:0] ru2, input logic [1:0] tu2,
                       input logic [4:0] rn,  input logic [1:0] tn,
                       input logic mds, input logic mdd, input logic mdu);
    d_r_use1 = ru1; d_t_use1 = tu1;
    d_r_use2 = ru2; d_t_use2 = tu2;
    d_r_new  = rn;  d_t_new  = tn;
    d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
  endtask

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_nop();
    drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One md start followed by mflo held in D until released.
  task automatic run_md(input logic div, input int unsigned n);
    @(negedge clk);
    drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, div, 1'b1);
    #1;
    chk("md_start_stall", {1'b0, stall}, 2'd0);
    chk("md_start_busy", {1'b0, md_busy}, 2'd0);
    for (int unsigned c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1);
      #1;
      chk($sformatf("md%0d_busy_c%0d", n, c), {1'b0, md_busy},
          {1'b0, (c >= 2 && c <= n + 1)});
      chk($sformatf("md%0d_stall_c%0d", n, c), {1'b0, stall},
          {1'b0, (c <= n + 1)});
    end
    @(negedge clk);
    drive_nop();
    #1;
    chk("md_after_busy", {1'b0, md_busy}, 2'd0);
  endtask

  initial begin
    // r_use1, t_use1, r_use2, t_use2, r_new, t_new, mds, mdd, mdu |
    // stall, fwd_d1, fwd_d2, fwd_e1, fwd_e2, md_busy
    vecs.push_back(mk(29,1, 0,0, 8,2, 0,0,0,  0,0,0,0,0,0)); // lw $8
    vecs.push_back(mk( 8,1, 8,1, 9,1, 0,0,0,  1,0,0,0,0,0)); // addu $9,$8,$8 load-use
    vecs.push_back(mk( 8,1, 8,1, 9,1, 0,0,0,  0,0,0,0,0,0)); // released
    vecs.push_back(mk( 0,0, 0,0, 0,0, 0,0,0,  0,0,0,2,2,0)); // addu in E takes W
    vecs.push_back(mk( 0,0, 0,0, 3,1, 0,0,0,  0,0,0,0,0,0)); // addu $3
    vecs.push_back(mk( 3,0, 0,0, 0,0, 0,0,0,  1,0,0,0,0,0)); // beq $3 stalls
    vecs.push_back(mk( 3,0, 0,0, 0,0, 0,0,0,  0,1,0,0,0,0)); // beq takes M
    vecs.push_back(mk( 0,0, 0,0, 0,1, 0,0,0,  0,0,0,2,0,0)); // addu $0; beq in E takes W
    vecs.push_back(mk( 0,0, 0,0, 0,0, 0,0,0,  0,0,0,0,0,0)); // beq $0 never stalls
    vecs.push_back(mk( 0,0, 0,0, 5,1, 0,0,0,  0,0,0,0,0,0)); // addu $5 (A1)
    vecs.push_back(mk( 0,0, 0,0, 5,1, 0,0,0,  0,0,0,0,0,0)); // addu $5 (A2)
    vecs.push_back(mk( 5,1, 0,0, 6,1, 0,0,0,  0,1,0,0,0,0)); // addu $6,$5
    vecs.push_back(mk( 0,0, 0,0, 0,0, 0,0,0,  0,0,0,1,0,0)); // E use: M(A2) over W(A1)
    vecs.push_back(mk( 5,0, 0,0, 0,0, 0,0,0,  0,2,0,0,0,0)); // beq $5 from W, no stall
    vecs.push_back(mk( 0,0, 0,0, 0,0, 0,0,0,  0,0,0,0,0,0));
    vecs.push_back(mk( 0,0, 0,0, 7,2, 0,0,0,  0,0,0,0,0,0)); // lw $7
    vecs.push_back(mk( 0,0, 7,1, 0,0, 0,0,0,  1,0,0,0,0,0)); // source-2 load-use
    vecs.push_back(mk( 0,0, 7,1, 0,0, 0,0,0,  0,0,0,0,0,0)); // M t_new=1 not forwarded
    vecs.push_back(mk( 0,0, 0,0, 0,0, 0,0,0,  0,0,0,0,2,0)); // E src2 from W
    vecs.push_back(mk( 0,0, 0,0, 4,2, 0,0,0,  0,0,0,0,0,0)); // lw $4
    vecs.push_back(mk( 0,0, 4,2, 0,0, 0,0,0,  0,0,0,0,0,0)); // t_new == t_use: no stall
    vecs.push_back(mk( 0,0, 0,0, 0,0, 0,0,0,  0,0,0,0,0,0)); // M t_new=1: E src2 from RF
    vecs.push_back(mk( 0,0, 0,0, 0,0, 0,0,0,  0,0,0,0,0,0));

    // Reset state
    rst_n = 1'b1;
    drive(5'd8, 2'd0, 5'd8, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #12;
    chk("rst_stall",   {1'b0, stall},   2'd0);
    chk("rst_busy",    {1'b0, md_busy}, 2'd0);
    chk("rst_fwd_d1",  fwd_d1, 2'd0);
    chk("rst_fwd_d2",  fwd_d2, 2'd0);
    chk("rst_fwd_e1",  fwd_e1, 2'd0);
    chk("rst_fwd_e2",  fwd_e2, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ru1, vecs[i].tu1, vecs[i].ru2, vecs[i].tu2,
            vecs[i].rn, vecs[i].tn, vecs[i].mds, vecs[i].mdd, vecs[i].mdu);
      #1;
      chk($sformatf("v%0d_stall", i), {1'b0, stall}, {1'b0, vecs[i].st});
      chk($sformatf("v%0d_busy", i),  {1'b0, md_busy}, {1'b0, vecs[i].busy});
      chk($sformatf("v%0d_fwd_e1", i), fwd_e1, vecs[i].fe1);
      chk($sformatf("v%0d_fwd_e2", i), fwd_e2, vecs[i].fe2);
      if (!vecs[i].st) begin
        chk($sformatf("v%0d_fwd_d1", i), fwd_d1, vecs[i].fd1);
        chk($sformatf("v%0d_fwd_d2", i), fwd_d2, vecs[i].fd2);
      end
    end

    run_md(1'b1, 10);
    run_md(1'b0, 5);

    // Reset mid-div, at busy cycle 4
    @(negedge clk);
    drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    for (int unsigned c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1);
    end
    #1;
    chk("pre_rst_busy",  {1'b0, md_busy}, 2'd1);
    chk("pre_rst_stall", {1'b0, stall},   2'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {1'b0, md_busy}, 2'd0);
    chk("mid_rst_stall", {1'b0, stall},   2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_busy",  {1'b0, md_busy}, 2'd0);
    chk("post_rst_stall", {1'b0, stall},   2'd0);
    @(negedge clk);
    drive_nop();
    #1;
    chk("post_rst_busy2", {1'b0, md_busy}, 2'd0);
    chk("post_rst_fwd_e1", fwd_e1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Sequencing controller for the 5-stage MIPS pipeline.
- Consumes the per-instruction register/timing tuple (r_use, t_use, r_new, t_new) produced in D stage by the timing decoder.
- Tracks the tuple internally for the E, M and W stages, ages t_new each cycle, and issues the D-stage stall.
- Drives the forwarding-mux selects for D and E operands and sequences the multi-cycle mult/div unit busy window.

Parameters:
- MULT_CYCLES, 5, E-stage busy cycles after a mult/multu start
- DIV_CYCLES, 10, E-stage busy cycles after a div/divu start
- CNT_W, 4, md busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- d_r_use1  in  5  D-stage source reg 1 (0 = unused)
- d_r_use2  in  5  D-stage source reg 2 (0 = unused)
- d_t_use1  in  2  cycles until source 1 is needed (0 = needed in D)
- d_t_use2  in  2  cycles until source 2 is needed
- d_r_new  in  5  D-stage destination reg (0 = none)
- d_t_new  in  2  cycles after entering E until result sits in a pipeline register
- d_md_start  in  1  D instruction is mult/multu/div/divu
- d_md_div  in  1  qualifies d_md_start: 1 = div
- d_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo/md start
- stall  out  1  freeze PC and F/D register, insert bubble into E
- fwd_d1  out  2  D operand 1 select
- fwd_d2  out  2  D operand 2 select
- fwd_e1  out  2  E operand 1 select
- fwd_e2  out  2  E operand 2 select
- md_busy  out  1  md unit computing

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk. While rst_n=0:
  - E/M/W shadow registers {r_new, t_new, r_use1, r_use2, md_start, md_div} clear to 0.
  - md counter clears to 0.
  - Consequently stall=0, md_busy=0, all fwd_*=0. Reset mid-operation abandons any md countdown.
- Shadow advance on every rising clk:
  - E <= stall ? bubble (all 0) : D tuple.
  - M <= E with t_new = sat0(E.t_new-1).
  - W <= M with t_new = sat0(M.t_new-1).
  - r_new and r_use pass through unchanged.
- Hazard stall (combinational), for each source k in {1,2} with d_r_usek != 0:
  - hit if E.r_new == d_r_usek and E.t_new > d_t_usek, or
  - hit if M.r_new == d_r_usek and M.t_new > d_t_usek.
  - W never causes a stall.
  - r_new == 0 never matches; $0 is never forwarded.
- md stall: d_md_use and (md_busy or E.md_start).
- stall = any hazard hit or md stall.
- Forward select encoding: 0 = register file / native value, 1 = M-stage result, 2 = W-stage result.
  - Select 1 when M.r_new == operand reg != 0 and M.t_new == 0.
  - Else select 2 when W.r_new matches (nonzero).
  - Else select 0. M has priority over W.
  - fwd_d* uses d_r_use*; fwd_e* uses E.r_use*.
  - fwd_d* is don't-care whenever stall=1.
- md counter:
  - When E.md_start=1 at a clock edge, load DIV_CYCLES if E.md_div else MULT_CYCLES.
  - Otherwise decrement while nonzero.
  - md_busy = (counter != 0), registered.
  - E.md_start while busy cannot occur, because the md stall blocks it.
- Simultaneous events:
  - Hazard and md stall in the same cycle produce one stall.
  - A stalled D instruction re-evaluates every cycle and stays stalled until both conditions clear.

Decomposition:
- Shared header hazard constants: FWD_RF=2'd0, FWD_M=2'd1, FWD_W=2'd2; stage-tuple field widths.
- Sub-module md_busy_cnt: load/decrement counter with MULT_CYCLES/DIV_CYCLES parameters and md_busy output.
- Shadow pipeline, stall logic and forward logic remain in hazard_sched.

Test Plan:
- Load-use: cycle0 D = lw $8 (r_new=8, t_new=2); cycle1 D = addu $9,$8,$8 (t_use=1) -> stall=1 for exactly 1 cycle, then fwd_e1=fwd_e2=2 when addu reaches E.
- Branch after ALU: D = addu $3 (t_new=1), next D = beq $3 (t_use=0) -> stall 1 cycle, then fwd_d1=1 (M).
- $0 destination: addu $0 followed by beq $0 (t_use=0) -> stall=0, fwd_d1=0.
- M-over-W priority: two back-to-back writes to $5 followed by a use of $5 -> fwd_*=1 selects the younger writer.
- md: div in E -> md_busy high 10 cycles; mflo in D meanwhile -> stall held until the cycle md_busy falls, then released.
- Reset mid-div: rst_n low at busy cycle 4 -> md_busy=0 and stall=0 immediately (asynchronous); shadows cleared.
